serial_ripple_adder: RTL

Bit-serial adder that computes the same result as a WIDTH-bit ripple-carry adder. It uses a single full-adder cell and a carry flip-flop, and processes one bit per clock, LSB first.
- Operands enter in parallel through a valid/ready handshake.
- The result leaves in parallel through a second valid/ready handshake.
- It is the area-reduced arithmetic block in the lab FPGA designs, and it is the unit the team's full-adder truth-table checks are applied to across a full word.

---
 rtl/serial_ripple_adder_pkg.sv | 28 ++
 rtl/serial_ripple_adder_if.sv | 31 +++
 rtl/serial_ripple_adder_fa_cell.sv | 17 +
 rtl/serial_ripple_adder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_ripple_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_add_pkg                                                           |
// | Shared state encoding, legal WIDTH range and counter sizing helper.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int C_WIDTH_MIN = 1;
    localparam int C_WIDTH_MAX = 32;

    // Bit counter width; clamps out-of-range widths and never returns zero.
    function automatic int cnt_width(input int width);
        int w;
        w = width;
        if (w < C_WIDTH_MIN) w = C_WIDTH_MIN;
        if (w > C_WIDTH_MAX) w = C_WIDTH_MAX;
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_ripple_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_ripple_adder_if                                                   |
// | Operand and result valid/ready handshakes of the bit-serial adder.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface serial_ripple_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, res_ready,
        input  in_ready, res_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, res_ready,
        output in_ready, res_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_ripple_adder_fa_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_fa_cell                                                           |
// | Purely combinational one-bit full adder.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_fa_cell (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic c_i,
    output logic      s_o,
    output logic      co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule
`default_nettype wire

// File: rtl/serial_ripple_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_ripple_adder                                                      |
// | Bit-serial WIDTH-bit adder: one full-adder cell, one bit per clock.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_ripple_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    serial_ripple_adder_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               w_fa_s;
    logic               w_fa_c;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sum_shift;

    serial_fa_cell u_fa (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .c_i  (carry_q),
        .s_o  (w_fa_s),
        .co_o (w_fa_c)
    );

    assign w_last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign w_accept = (state_q == IDLE) && bus.in_valid;

    // The bit leaving sum_sr at position 0 is already superseded; only the
    // shifted word matters.
    if (WIDTH == 1) begin : g_w1
        assign w_sum_shift = w_fa_s;
        logic w_unused_sr;
        assign w_unused_sr = &{1'b0, sum_sr_q};
    end else begin : g_wn
        assign w_sum_shift = {w_fa_s, sum_sr_q[WIDTH-1:1]};
        logic w_unused_sr;
        assign w_unused_sr = &{1'b0, sum_sr_q[0]};
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (w_last)        state_d = HOLD;
            HOLD:    if (bus.res_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: handshake flags come straight from the state register
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            HOLD:    bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        if (w_accept) begin
            a_sr_d   = bus.a;
            b_sr_d   = bus.b;
            sum_sr_d = '0;
            carry_d  = bus.cin;
            cnt_d    = '0;
        end else if (state_q == SHIFT) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = w_sum_shift;
            carry_d  = w_fa_c;
            if (w_last) begin
                // carry_q is still the carry into the MSB at this point.
                sum_d  = w_sum_shift;
                cout_d = w_fa_c;
                ovf_d  = carry_q ^ w_fa_c;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
`default_nettype wire
